// File: rtl/fetch_module_if.sv
// rtl/fetch_module_if.sv - fetch stage control, imem and dispatch-side signal bundle
interface fetch_module_if;
    logic        in_start;
    logic        in_stall;
    logic        in_redirect;
    logic [63:0] in_redirect_pc;
    logic        out_imem_req;
    logic [63:0] out_imem_addr;
    logic [31:0] in_imem_data;
    logic [31:0] out_insnbits;
    logic [63:0] out_pc;
    logic        out_fetch_done;
    logic        out_halted;

    modport master (
        input  in_start,
        input  in_stall,
        input  in_redirect,
        input  in_redirect_pc,
        input  in_imem_data,
        output out_imem_req,
        output out_imem_addr,
        output out_insnbits,
        output out_pc,
        output out_fetch_done,
        output out_halted
    );

    modport slave (
        output in_start,
        output in_stall,
        output in_redirect,
        output in_redirect_pc,
        output in_imem_data,
        input  out_imem_req,
        input  out_imem_addr,
        input  out_insnbits,
        input  out_pc,
        input  out_fetch_done,
        input  out_halted
    );
endinterface

// File: rtl/fetch_module.sv
// rtl/fetch_module.sv - instruction fetch: PC, 1-cycle imem requests, head FIFO to dispatch
// Optional halt detection (HLT drains then halts) enabled by FETCH_HALT_DETECT_EN.
module fetch_module #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic          in_clk,
    input  logic          in_rst,
    fetch_module_if.master bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [63:0]        pc;
    logic               inflight;
    logic [63:0]        inflight_pc;
    logic [31:0]        q_data [QUEUE_DEPTH];
    logic [63:0]        q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic req;
    logic enq;
    logic deq;
    logic head_valid;
    logic halt_word;

    // Credits count both queued entries and the in-flight response so the FIFO can never overflow.
    always_comb begin
        head_valid = (count != '0);
        req = (state == ST_RUN) && !bus.in_redirect &&
              (({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C);
        enq = inflight && (state == ST_RUN) && !bus.in_redirect;
        deq = head_valid && !bus.in_stall && !bus.in_redirect;
`ifdef FETCH_HALT_DETECT_EN
        halt_word = ((bus.in_imem_data & 32'hFFE0_001F) == 32'hD440_0000);
`else
        halt_word = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.in_start) state_nxt = ST_RUN;
            ST_RUN:    if (enq && halt_word) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (count == '0) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
        if (bus.in_redirect && (state != ST_IDLE)) state_nxt = ST_RUN;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= req;
            if (bus.in_redirect) begin
                pc     <= bus.in_redirect_pc & ~64'd3;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (req) pc <= pc + 64'd4;
                if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
                if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({enq, deq})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (req) inflight_pc <= pc;
        if (enq && !in_rst) begin
            q_data[wr_ptr] <= bus.in_imem_data;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

    assign bus.out_imem_req   = req;
    assign bus.out_imem_addr  = pc;
    assign bus.out_fetch_done = head_valid;
    assign bus.out_insnbits   = head_valid ? q_data[rd_ptr] : 32'd0;
    assign bus.out_pc         = head_valid ? q_pc[rd_ptr] : 64'd0;
`ifdef FETCH_HALT_DETECT_EN
    assign bus.out_halted     = (state == ST_HALTED);
`else
    assign bus.out_halted     = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_module.sv
// tb/tb_fetch_module.sv - directed scoreboard bench for fetch_module (both FETCH_HALT_DETECT_EN builds)
module tb_fetch_module;
    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] HLT    = 32'hD440_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } item_t;

    logic in_clk = 1'b0;
    logic in_rst;
    fetch_module_if bus();

    fetch_module #(.RESET_PC(RST_PC), .QUEUE_DEPTH(4)) dut (
        .in_clk(in_clk),
        .in_rst(in_rst),
        .bus(bus)
    );

    always #5 in_clk = ~in_clk;

    int          errors = 0;
    int          checks = 0;
    item_t       sb[$];
    logic [63:0] exp_next_pc = RST_PC;
    logic        hlt_en = 1'b0;
    logic [63:0] hlt_pc = 64'd8;
    logic        halt_drop = 1'b0;
    int          post_hlt = 0;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (hlt_en && (a == hlt_pc)) ? HLT : a[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction memory: one-cycle latency, returns the address (or HLT) as data.
    always @(posedge in_clk)
        bus.in_imem_data <= bus.out_imem_req ? word_of(bus.out_imem_addr) : 32'hDEAD_BEEF;

    // Request tracker pushes expected deliveries; dequeue monitor pops and compares.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            if (bus.out_imem_req) begin
                check("req_addr", bus.out_imem_addr, exp_next_pc);
                if (halt_drop) begin
                    check("post_hlt_req_count", 64'(post_hlt), 64'd0);
                    post_hlt++;
                end else begin
                    sb.push_back({exp_next_pc, word_of(exp_next_pc)});
                end
`ifdef FETCH_HALT_DETECT_EN
                if (hlt_en && (exp_next_pc == hlt_pc)) halt_drop = 1'b1;
`endif
                exp_next_pc = exp_next_pc + 64'd4;
            end
            if (bus.out_fetch_done && !bus.in_stall && !bus.in_redirect) begin
                if (sb.size() == 0) begin
                    check("deq_unexpected_fetch_done", 64'(bus.out_fetch_done), 64'd0);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    check("head_pc", bus.out_pc, it.pc);
                    check("head_insn", 64'(bus.out_insnbits), 64'(it.insn));
                end
            end
        end
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge in_clk);
    endtask

    task automatic do_reset();
        tick();
        in_rst = 1'b1;
        bus.in_start = 1'b0;
        bus.in_stall = 1'b0;
        bus.in_redirect = 1'b0;
        bus.in_redirect_pc = 64'd0;
        sb.delete();
        exp_next_pc = RST_PC;
        halt_drop = 1'b0;
        post_hlt = 0;
        hlt_en = 1'b0;
        tick();
        tick();
        in_rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_req"},     64'(bus.out_imem_req), 64'd0);
        check({ph, "_addr"},    bus.out_imem_addr, RST_PC);
        check({ph, "_insn"},    64'(bus.out_insnbits), 64'd0);
        check({ph, "_pc"},      bus.out_pc, 64'd0);
        check({ph, "_done"},    64'(bus.out_fetch_done), 64'd0);
        check({ph, "_halted"},  64'(bus.out_halted), 64'd0);
    endtask

    // Cycles 0..2 after reset: start pulse, first request, first response.
    task automatic start_seq();
        tick(); bus.in_start = 1'b1; mid();
        check("start_c0_req", 64'(bus.out_imem_req), 64'd0);
        tick(); bus.in_start = 1'b0; mid();
        check("start_c1_req", 64'(bus.out_imem_req), 64'd1);
        check("start_c1_addr", bus.out_imem_addr, RST_PC);
        tick(); mid();
        check("start_c2_done", 64'(bus.out_fetch_done), 64'd0);
    endtask

    initial begin
        in_rst = 1'b1;
        bus.in_start = 1'b0;
        bus.in_stall = 1'b0;
        bus.in_redirect = 1'b0;
        bus.in_redirect_pc = 64'd0;

        // Reset state and free-running stream
        do_reset(); mid();
        check_reset_outputs("rst");
        start_seq();
        for (int i = 0; i < 8; i++) begin
            tick(); mid();
            check("a_stream_done", 64'(bus.out_fetch_done), 64'd1);
        end

        // Stall from cycle 3 fills the FIFO, release resumes at PC 0x10
        do_reset(); mid();
        start_seq();
        for (int c = 3; c <= 8; c++) begin
            tick(); bus.in_stall = 1'b1; mid();
            check("b_head_pc", bus.out_pc, 64'd0);
            check("b_head_insn", 64'(bus.out_insnbits), 64'd0);
            if (c >= 5) check("b_full_req", 64'(bus.out_imem_req), 64'd0);
        end
        tick(); bus.in_stall = 1'b0; mid();
        check("b_release_req", 64'(bus.out_imem_req), 64'd0);
        tick(); mid();
        check("b_resume_req", 64'(bus.out_imem_req), 64'd1);
        check("b_resume_addr", bus.out_imem_addr, 64'h10);
        repeat (6) begin tick(); mid(); end

        // Redirect with 3 queued and one in flight, while stalled
        do_reset(); mid();
        start_seq();
        tick(); bus.in_stall = 1'b1; mid();
        tick(); mid();
        tick();
        bus.in_redirect = 1'b1;
        bus.in_redirect_pc = 64'h1003;
        sb.delete();
        exp_next_pc = 64'h1000;
        mid();
        check("c_redir_req", 64'(bus.out_imem_req), 64'd0);
        tick(); bus.in_redirect = 1'b0; bus.in_stall = 1'b0; mid();
        check("c_n1_done", 64'(bus.out_fetch_done), 64'd0);
        check("c_n1_req", 64'(bus.out_imem_req), 64'd1);
        check("c_n1_addr", bus.out_imem_addr, 64'h1000);
        tick(); mid();
        check("c_n2_done", 64'(bus.out_fetch_done), 64'd0);
        tick(); mid();
        check("c_n3_done", 64'(bus.out_fetch_done), 64'd1);
        check("c_n3_pc", bus.out_pc, 64'h1000);
        repeat (4) begin tick(); mid(); end

        // PC wrap at 2^64
        tick();
        bus.in_redirect = 1'b1;
        bus.in_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        sb.delete();
        exp_next_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        mid();
        tick(); bus.in_redirect = 1'b0; mid();
        check("d_top_addr", bus.out_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); mid();
        check("d_wrap_req", 64'(bus.out_imem_req), 64'd1);
        check("d_wrap_addr", bus.out_imem_addr, 64'd0);
        repeat (5) begin tick(); mid(); end

        // HLT at PC 8
        do_reset(); mid();
        hlt_en = 1'b1;
        start_seq();
        repeat (12) begin tick(); mid(); end
`ifdef FETCH_HALT_DETECT_EN
        check("e_halted", 64'(bus.out_halted), 64'd1);
        check("e_halt_done", 64'(bus.out_fetch_done), 64'd0);
        check("e_halt_req", 64'(bus.out_imem_req), 64'd0);
        check("e_post_hlt_reqs", 64'(post_hlt), 64'd1);
`else
        check("e_not_halted", 64'(bus.out_halted), 64'd0);
        check("e_running_done", 64'(bus.out_fetch_done), 64'd1);
`endif
        tick();
        bus.in_redirect = 1'b1;
        bus.in_redirect_pc = 64'h20;
        sb.delete();
        exp_next_pc = 64'h20;
        halt_drop = 1'b0;
        post_hlt = 0;
        hlt_en = 1'b0;
        mid();
        tick(); bus.in_redirect = 1'b0; mid();
        check("e_redir_halted", 64'(bus.out_halted), 64'd0);
        check("e_redir_req", 64'(bus.out_imem_req), 64'd1);
        check("e_redir_addr", bus.out_imem_addr, 64'h20);
        repeat (4) begin tick(); mid(); end

        // Reset with 2 queued and a response pending
        do_reset(); mid();
        start_seq();
        tick(); bus.in_stall = 1'b1; mid();
        tick();
        in_rst = 1'b1;
        sb.delete();
        exp_next_pc = RST_PC;
        mid();
        tick(); in_rst = 1'b0; bus.in_stall = 1'b0; mid();
        check_reset_outputs("f_rst");
        tick(); mid();
        check("f_stale_done", 64'(bus.out_fetch_done), 64'd0);
        check("f_idle_req", 64'(bus.out_imem_req), 64'd0);
        tick(); mid();
        check("f_idle_req2", 64'(bus.out_imem_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_module.md
# fetch_module

Instruction fetch stage of the Tomasulo core, directly upstream of `dispatch`. It keeps the architectural fetch PC and issues one 4-byte request per cycle to a synchronous instruction memory with one-cycle latency. Returned instruction words go into a small FIFO, and the FIFO head drives `dispatch` as `in_insnbits`/`in_fetch_done`. It back-pressures on the dispatch stall and flushes on a misprediction redirect.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `QUEUE_DEPTH`, default 4: fetch FIFO entries; power of two, ≥2.
- `in_clk` in 1: core clock; all state updates on rising edge.
- `in_rst` in 1: reset, synchronous and active-high.
- `in_start` in 1: leave IDLE and begin fetching.
- `in_stall` in 1: dispatch cannot accept this cycle (driven from dispatch `out_stalled`).
- `in_redirect` in 1: misprediction redirect; flush and refetch.
- `in_redirect_pc` in 64: redirect target; bits [1:0] ignored (forced 0).
- `out_imem_req` out 1: imem read request this cycle.
- `out_imem_addr` out 64: request address (current PC).
- `in_imem_data` in 32: instruction word; valid exactly one cycle after an accepted `out_imem_req`.
- `out_insnbits` out 32: FIFO head instruction; 0 when FIFO empty.
- `out_pc` out 64: PC of FIFO head; 0 when empty.
- `out_fetch_done` out 1: FIFO non-empty; head valid.
- `out_halted` out 1: halt reached (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN, HALTED. Reset → IDLE.
  - IDLE → RUN on `in_start`. `in_start` is ignored in every other state.
  - RUN → DRAIN when a halt word is enqueued.
  - DRAIN → HALTED when the FIFO is empty.
  - `in_redirect` in RUN, DRAIN or HALTED → RUN.
- Request: `out_imem_req = (state==RUN) && !in_redirect && (count + inflight) < QUEUE_DEPTH`. This is combinational from registered state plus `in_redirect`.
- On each request: PC ← PC + 4, 64-bit modular, wraps at 2^64. `inflight` is set for one cycle.
- Response: if `inflight` is set, `in_imem_data` is enqueued with its PC on the next edge. The credit check guarantees the FIFO never overflows.
- Dequeue: occurs at the edge where `out_fetch_done && !in_stall`. Enqueue and dequeue may coincide; count is then unchanged.
- Redirect, highest priority:
  - FIFO cleared, count ← 0.
  - Any same-cycle response is dropped and `inflight` cleared.
  - PC ← `in_redirect_pc & ~3`.
  - No dequeue is reported that cycle.
  - Redirect in IDLE updates the PC only and stays IDLE.
- Stall plus redirect in the same cycle: the redirect wins.
- `out_halted = (state==HALTED)`.

## Timing
- Reset values: `out_imem_req` 0, `out_imem_addr` RESET_PC, `out_insnbits` 0, `out_pc` 0, `out_fetch_done` 0, `out_halted` 0.
- Reset mid-operation clears FIFO, `inflight` and FSM. A response arriving the cycle after reset is discarded.
- Start latency:
  - `in_start` high in cycle 0.
  - `out_imem_req` with addr RESET_PC in cycle 1.
  - Data in cycle 2.
  - `out_fetch_done` in cycle 3.
- Redirect latency: redirect in cycle N → request to target in N+1 → head valid in N+3.
- Throughput: 1 instruction/cycle sustained with no stall.
- When stalled, the FIFO fills to QUEUE_DEPTH and requests cease. The first request resumes in the cycle after the first dequeue frees a credit.
- Head outputs are stable while `in_stall` is held.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - A word matching `(w & 32'hFFE0001F) == 32'hD4400000` (HLT) sends RUN → DRAIN on enqueue.
  - No further requests are issued, and the HLT itself is still delivered to dispatch.
  - The FSM enters HALTED once the FIFO empties; `out_halted` goes to 1.
- Undefined:
  - HLT is an ordinary word, and DRAIN/HALTED are unreachable.
  - `out_halted` is tied to 0.

## Test plan
- Reset then `in_start`, imem returns `addr` as data, no stall → requests 0,4,8,… from cycle 1. Head 0x0 at cycle 3, then one instruction per cycle.
- Hold `in_stall` from cycle 3 → FIFO fills to 4 and `out_imem_req` drops; the head stays at PC 0. Release the stall → the next request is PC 0x10, one cycle after the first dequeue.
- Redirect to 0x1003 while 3 entries are queued and a response is in flight → `out_fetch_done` is 0 the next cycle and the in-flight word is dropped. The next request goes to 0x1000, with the head valid 3 cycles after the redirect.
- PC at 64'hFFFF_FFFF_FFFF_FFFC → the next request addr is 0.
- With `FETCH_HALT_DETECT_EN`, HLT (0xD4400000) at PC 8 → no request past PC 8 after it returns. Instructions 0,4,8 are delivered, then `out_halted`=1. A redirect to 0x20 → back to RUN with `out_halted`=0.
- Assert `in_rst` while 2 entries are queued and a response is pending → the next cycle has all outputs at their reset values and state IDLE. The stale response is not enqueued.
